video_window_calc: RTL



---
 rtl/video_window_calc_pkg.sv | 51 +++++
 rtl/sys_udiv.sv | 73 +++++++
 rtl/sys_umul.sv | 68 ++++++
 rtl/video_window_center.sv | 47 ++++
 rtl/video_window_calc.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/video_window_calc_pkg.sv
// Shared types and helpers for the output display-window calculator.
package video_window_calc_pkg;

  localparam int unsigned DIM_W           = 12;
  localparam int unsigned AR_W            = 13;
  localparam int unsigned PROD_W          = 24;
  localparam int unsigned AR_EXPLICIT_BIT = 12;

  typedef enum logic [3:0] {
    WIN_IDLE,
    WIN_START,
    WIN_MODE,
    WIN_MUL1,
    WIN_DIV1,
    WIN_FIT,
    WIN_MUL2,
    WIN_DIV2,
    WIN_CENTER,
    WIN_COMMIT
  } win_state_t;

  // Display window in output pixel/line coordinates, consumed by the scaler.
  typedef struct packed {
    logic [DIM_W-1:0] hmin;
    logic [DIM_W-1:0] hmax;
    logic [DIM_W-1:0] vmin;
    logic [DIM_W-1:0] vmax;
  } win_t;

  // Snapshot of everything the window depends on.
  typedef struct packed {
    logic [AR_W-1:0]  arx;
    logic [AR_W-1:0]  ary;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
  } win_req_t;

  // Saturate a wide quotient into a window dimension.
  function automatic logic [DIM_W-1:0] sat_dim(input logic [PROD_W-1:0] q);
    if (q[PROD_W-1:DIM_W] != '0) sat_dim = '1;
    else                         sat_dim = q[DIM_W-1:0];
  endfunction

  // Explicit size request: zero or oversize falls back to the full screen dimension.
  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] req,
                                                 input logic [DIM_W-1:0] lim);
    if (req == '0 || req > lim) clamp_dim = lim;
    else                        clamp_dim = req;
  endfunction

endpackage

// File: rtl/sys_udiv.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
module sys_udiv #(
  parameter int unsigned NW = 24,
  parameter int unsigned DW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          run_o,
  output logic [NW-1:0] quot_o
);

  localparam int unsigned CW = $clog2(NW + 1);

  logic [NW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [DW:0]   rem_sh_c;

  // Dividend bits shift out of quo_q as quotient bits shift in; a zero divisor yields all ones.
  always_comb begin
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    rem_sh_c = {rem_q, quo_q[NW-1]};
    if (!run_q) begin
      if (start_i) begin
        quo_d = dividend_i;
        rem_d = '0;
        dvs_d = divisor_i;
        cnt_d = CW'(NW);
        run_d = 1'b1;
      end
    end else begin
      if (rem_sh_c >= {1'b0, dvs_q}) begin
        rem_d = DW'(rem_sh_c - {1'b0, dvs_q});
        quo_d = {quo_q[NW-2:0], 1'b1};
      end else begin
        rem_d = rem_sh_c[DW-1:0];
        quo_d = {quo_q[NW-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign run_o  = run_q;
  assign quot_o = quo_q;

endmodule

// File: rtl/sys_umul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
module sys_umul #(
  parameter int unsigned AW = 12,
  parameter int unsigned BW = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AW-1:0]    a_i,
  input  logic [BW-1:0]    b_i,
  output logic             run_o,
  output logic [AW+BW-1:0] p_o
);

  localparam int unsigned PW = AW + BW;
  localparam int unsigned CW = $clog2(BW + 1);

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [BW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  // Load operands on start (ignored while running), then accumulate one bit per cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (!run_q) begin
      if (start_i) begin
        acc_d    = '0;
        mcand_d  = PW'(a_i);
        mplier_d = b_i;
        cnt_d    = CW'(BW);
        run_d    = 1'b1;
      end
    end else begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign run_o = run_q;
  assign p_o   = acc_q;

endmodule

// File: rtl/video_window_center.sv
// Centres a w x h picture on a W x H screen and holds the resulting window.
module video_window_center
  import video_window_calc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             blank_i,
  input  logic [DIM_W-1:0] scr_w_i,
  input  logic [DIM_W-1:0] scr_h_i,
  input  logic [DIM_W-1:0] win_w_i,
  input  logic [DIM_W-1:0] win_h_i,
  output win_t             win_o
);

  localparam int unsigned EXT_W = DIM_W + 1;

  logic [DIM_W-1:0] hmin_c, hmax_c, vmin_c, vmax_c;
  win_t             win_q;

  // Edge offsets use one spare bit so the subtract/add chain cannot wrap early.
  always_comb begin
    hmin_c = DIM_W'(({1'b0, scr_w_i} - {1'b0, win_w_i}) >> 1);
    hmax_c = DIM_W'({1'b0, hmin_c} + {1'b0, win_w_i} - EXT_W'(1));
    vmin_c = DIM_W'(({1'b0, scr_h_i} - {1'b0, win_h_i}) >> 1);
    vmax_c = DIM_W'({1'b0, vmin_c} + {1'b0, win_h_i} - EXT_W'(1));
  end

  // Window register: all four edges change together on load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else if (load_i) begin
      if (blank_i) begin
        win_q <= '0;
      end else begin
        win_q.hmin <= hmin_c;
        win_q.hmax <= hmax_c;
        win_q.vmin <= vmin_c;
        win_q.vmax <= vmax_c;
      end
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/video_window_calc.sv
// Computes the centred output display window from HDMI size and aspect/explicit size.
module video_window_calc
  import video_window_calc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  input  logic [DIM_W-1:0] HDMI_WIDTH,
  input  logic [DIM_W-1:0] HDMI_HEIGHT,
  input  logic [AR_W-1:0]  ARX,
  input  logic [AR_W-1:0]  ARY,
  output logic [DIM_W-1:0] HMIN,
  output logic [DIM_W-1:0] HMAX,
  output logic [DIM_W-1:0] VMIN,
  output logic [DIM_W-1:0] VMAX,
  output logic             WIN_UPD,
  output logic             BUSY
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);

  win_state_t       state_q, state_d;
  win_req_t         cur_c, prev_q, snap_q, snap_d;
  logic             change_c;
  logic             pending_q, pending_d;
  logic [DIM_W-1:0] wv_q, wv_d, hv_q, hv_d;
  logic             blank_q, blank_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic             issued_q, issued_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             busy_q, busy_d;
  logic             upd_q, upd_d;
  logic             commit_c;

  logic              mul_start_c, mul_run;
  logic [DIM_W-1:0]  mul_a_c, mul_b_c;
  logic [PROD_W-1:0] mul_p;
  logic              div_start_c, div_run;
  logic [DIM_W-1:0]  div_dvs_c;
  logic [PROD_W-1:0] div_q;
  win_t              win;

  assign cur_c    = '{arx: ARX, ary: ARY, width: HDMI_WIDTH, height: HDMI_HEIGHT};
  assign change_c = (cur_c != prev_q);

  // Previous-cycle copy of the inputs for change detection.
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) prev_q <= '0;
    else          prev_q <= cur_c;
  end

  // Shared-unit operand selection: pass 1 fits height, pass 2 fits width.
  always_comb begin
    mul_a_c   = (state_q == WIN_MUL2) ? snap_q.width : snap_q.height;
    mul_b_c   = (state_q == WIN_MUL2) ? snap_q.ary[DIM_W-1:0] : snap_q.arx[DIM_W-1:0];
    div_dvs_c = (state_q == WIN_DIV2) ? snap_q.arx[DIM_W-1:0] : snap_q.ary[DIM_W-1:0];
  end

  sys_umul #(.AW(DIM_W), .BW(DIM_W)) u_mul (
    .clk_i   (CLK_VIDEO),
    .rst_ni  (RESET_N),
    .start_i (mul_start_c),
    .a_i     (mul_a_c),
    .b_i     (mul_b_c),
    .run_o   (mul_run),
    .p_o     (mul_p)
  );

  sys_udiv #(.NW(PROD_W), .DW(DIM_W)) u_div (
    .clk_i      (CLK_VIDEO),
    .rst_ni     (RESET_N),
    .start_i    (div_start_c),
    .dividend_i (prod_q),
    .divisor_i  (div_dvs_c),
    .run_o      (div_run),
    .quot_o     (div_q)
  );

  video_window_center u_center (
    .clk_i   (CLK_VIDEO),
    .rst_ni  (RESET_N),
    .load_i  (commit_c),
    .blank_i (blank_q),
    .scr_w_i (snap_q.width),
    .scr_h_i (snap_q.height),
    .win_w_i (wv_q),
    .win_h_i (hv_q),
    .win_o   (win)
  );

  // FSM state register.
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) state_q <= WIN_IDLE;
    else          state_q <= state_d;
  end

  // Next-state, unit handshakes and datapath updates.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    pending_d   = pending_q;
    wv_d        = wv_q;
    hv_d        = hv_q;
    blank_d     = blank_q;
    prod_d      = prod_q;
    issued_d    = issued_q;
    mul_start_c = 1'b0;
    div_start_c = 1'b0;
    commit_c    = 1'b0;

    unique case (state_q)
      WIN_IDLE: begin
        if (pending_q || change_c) begin
          state_d   = WIN_START;
          pending_d = 1'b0;
        end
      end
      WIN_START: begin
        snap_d   = cur_c;
        issued_d = 1'b0;
        state_d  = WIN_MODE;
      end
      WIN_MODE: begin
        blank_d = 1'b0;
        wv_d    = snap_q.width;
        hv_d    = snap_q.height;
        state_d = WIN_CENTER;
        if (snap_q.width == '0 || snap_q.height == '0) begin
          blank_d = 1'b1;
        end else if (snap_q.arx[AR_EXPLICIT_BIT] && snap_q.ary[AR_EXPLICIT_BIT]) begin
          wv_d = clamp_dim(snap_q.arx[DIM_W-1:0], snap_q.width);
          hv_d = clamp_dim(snap_q.ary[DIM_W-1:0], snap_q.height);
        end else if (snap_q.arx[DIM_W-1:0] != '0 && snap_q.ary[DIM_W-1:0] != '0) begin
          // A zero ratio field (including 0:0) keeps the full screen instead of dividing by zero.
          state_d = WIN_MUL1;
        end
      end
      WIN_MUL1, WIN_MUL2: begin
        if (!issued_q) begin
          if (!mul_run) begin
            mul_start_c = 1'b1;
            issued_d    = 1'b1;
          end
        end else if (!mul_run) begin
          prod_d   = mul_p;
          issued_d = 1'b0;
          state_d  = (state_q == WIN_MUL1) ? WIN_DIV1 : WIN_DIV2;
        end
      end
      WIN_DIV1, WIN_DIV2: begin
        if (!issued_q) begin
          if (!div_run) begin
            div_start_c = 1'b1;
            issued_d    = 1'b1;
          end
        end else if (!div_run) begin
          issued_d = 1'b0;
          if (state_q == WIN_DIV1) begin
            wv_d    = sat_dim(div_q);
            hv_d    = snap_q.height;
            state_d = WIN_FIT;
          end else begin
            wv_d    = snap_q.width;
            hv_d    = sat_dim(div_q);
            state_d = WIN_CENTER;
          end
        end
      end
      WIN_FIT: begin
        state_d = (wv_q <= snap_q.width) ? WIN_CENTER : WIN_MUL2;
      end
      WIN_CENTER: begin
        commit_c = 1'b1;
        state_d  = WIN_COMMIT;
      end
      WIN_COMMIT: begin
        state_d = WIN_IDLE;
      end
      default: begin
        state_d = WIN_IDLE;
      end
    endcase

    // Any input change abandons the work in flight; COMMIT restarts too so the change is not lost.
    if (state_q != WIN_IDLE && change_c) begin
      state_d     = WIN_START;
      issued_d    = 1'b0;
      mul_start_c = 1'b0;
      div_start_c = 1'b0;
      commit_c    = 1'b0;
    end
  end

  // Registered status flags and result-wait watchdog counter.
  always_comb begin
    busy_d = (state_d != WIN_IDLE);
    upd_d  = (state_d == WIN_COMMIT);
    if (!issued_d)          wait_d = '0;
    else if (wait_q == '1)  wait_d = wait_q;
    else                    wait_d = wait_q + 1'b1;
  end

  // Datapath and status registers.
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      snap_q    <= '0;
      pending_q <= 1'b1;
      wv_q      <= '0;
      hv_q      <= '0;
      blank_q   <= 1'b0;
      prod_q    <= '0;
      issued_q  <= 1'b0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      pending_q <= pending_d;
      wv_q      <= wv_d;
      hv_q      <= hv_d;
      blank_q   <= blank_d;
      prod_q    <= prod_d;
      issued_q  <= issued_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      upd_q     <= upd_d;
    end
  end

  // No single multiply or divide may take longer than MAX_WAIT cycles.
  a_wait_bound: assert property (@(posedge CLK_VIDEO) disable iff (!RESET_N)
                                 wait_q <= WAIT_W'(MAX_WAIT));

  assign HMIN    = win.hmin;
  assign HMAX    = win.hmax;
  assign VMIN    = win.vmin;
  assign VMAX    = win.vmax;
  assign WIN_UPD = upd_q;
  assign BUSY    = busy_q;

endmodule
